ifetch_queue: RTL
=================

Name: ifetch_queue

Overview:
- Instruction-fetch stage directly downstream of the program counter register.
- Accepts fetch addresses from the PC and issues in-order read requests to instruction memory.
- Captures returned words in a DEPTH-entry in-order queue and presents {pc, instruction} pairs to decode with a valid/ready handshake.
- A flush input handles branch/jump redirect: it discards queued words and drops in-flight responses.

Parameters:
- DEPTH, 4: queue entries; maximum requests outstanding plus buffered. Power of 2, at least 2.
- ADDR_W, 32: fetch address width.
- DATA_W, 32: instruction word width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_addr  in  ADDR_W  fetch address from the PC.
- pc_valid  in  1  pc_addr is valid for fetch.
- pc_ready  out  1  address accepted this cycle; the PC may advance.
- flush  in  1  redirect; kills all queued and in-flight fetches.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  ADDR_W  request address, word-aligned.
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  read data valid; responses return in request order, at least 1 cycle after gnt.
- imem_rdata  in  DATA_W  read data.
- inst_valid  out  1  head entry is filled and presented.
- inst_pc  out  ADDR_W  address of the presented instruction.
- inst_data  out  DATA_W  presented instruction.
- inst_ready  in  1  decode consumes the head entry this cycle.
- q_count  out  clog2(DEPTH)+1  allocated entries, filled or unfilled.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, rst_n=0): all pointers, q_count, drop counter and proto_err go to 0. inst_valid=0, inst_pc=0, inst_data=0, imem_req=0, pc_ready=0.
- Each entry holds {pc, data, filled}. Three pointers: alloc_ptr, fill_ptr, head_ptr, each wrapping modulo DEPTH.
- imem_req = pc_valid & ~flush & (q_count < DEPTH). q_count is the registered value at cycle start; a pop in the same cycle does not free a slot for allocation.
- imem_addr = {pc_addr[ADDR_W-1:2], 2'b00}. The low bits are ignored.
- pc_ready = imem_req & imem_gnt, combinational.
- Allocation: on imem_req & imem_gnt, the entry at alloc_ptr gets pc = aligned address and filled = 0. alloc_ptr increments; q_count increments.
- Fill: on imem_rvalid with drop counter = 0, the entry at fill_ptr gets data = imem_rdata and filled = 1. fill_ptr increments.
- If imem_rvalid arrives while no unfilled entry exists and the drop counter = 0, the data is ignored and proto_err is set.
- Presentation: inst_valid = filled[head_ptr] & (q_count != 0), driven from registered state. Latency: gnt in cycle N, rvalid in N+1, inst_valid in N+2.
- Pop: on inst_valid & inst_ready, head_ptr increments and q_count decrements.
- Simultaneous allocate and pop: q_count is unchanged and both pointers advance.
- inst_pc and inst_data hold steady while inst_valid=1 and inst_ready=0.
- Flush (registered effect):
  - All entries are freed; head_ptr, fill_ptr and alloc_ptr reset to 0; q_count goes to 0.
  - The drop counter loads the number of unfilled allocated entries.
  - No request is issued in the flush cycle. A pop in the flush cycle has no effect beyond the flush.
  - An rvalid arriving in the flush cycle counts toward that cycle's unfilled total and is dropped.
- Drop counter: each imem_rvalid while the counter is nonzero decrements it and discards the data.
  - New requests may issue from the cycle after flush; in-order return guarantees they arrive after the dropped ones.
  - The counter saturates at DEPTH.
- Back-to-back flushes: the second flush adds its unfilled count to the remaining drop count.
- Reset mid-operation clears everything. Discarding responses to pre-reset requests is the memory's responsibility.
- proto_err clears only on reset.

Test Plan:
- Streaming: pc_addr 0x0,0x4,0x8,0xC with gnt=1 every cycle and rvalid 1 cycle later, data 0xA0..0xA3, inst_ready=1. Expect inst_pc 0x0..0xC with matching data, the first inst_valid 2 cycles after the first gnt, and no bubbles.
- Full queue: DEPTH=4, inst_ready=0, 4 grants with 4 responses. Expect q_count=4 and imem_req=0 with pc_valid=1. Raising inst_ready for 1 cycle pops 0x0, and imem_req reasserts the next cycle.
- Flush in flight: 3 grants (0x10,0x14,0x18), 1 response returned, then flush. Expect q_count=0, inst_valid=0 and drop counter=2. The next 2 rvalids are discarded; a new request at 0x40 returns 0x40 with its own data.
- Stall hold: inst_valid=1 with inst_ready=0 for 5 cycles while the other entries fill. Expect inst_pc and inst_data stable, and order preserved after release.
- Misalignment and error: pc_addr=0x23 gives imem_addr=0x20 and inst_pc=0x20. An unsolicited rvalid with an empty queue sets proto_err=1, which holds until rst_n=0.
- Async reset: assert rst_n=0 mid-stream, between clock edges. Expect all outputs 0 immediately; after release, fetch resumes cleanly from the next pc_addr.

Source files
------------

// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
//   Instruction-fetch stage that sits just after the PC register. It accepts
//   fetch addresses, sends in-order read requests to instruction memory, and
//   keeps the returned words in a DEPTH-entry in-order queue. The head entry
//   is offered to decode as a {pc, instruction} pair with a valid/ready
//   handshake. A flush (branch/jump redirect) frees every entry. Responses
//   that are still in flight at that point are counted and discarded when
//   they come back.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   pc_addr/pc_valid      fetch address offered by the PC
//   pc_ready              address accepted this cycle (request granted)
//   flush                 redirect: kill queued and in-flight fetches
//   imem_req/imem_addr    read request to instruction memory (word aligned)
//   imem_gnt              memory accepted the request
//   imem_rvalid/rdata     in-order read response
//   inst_valid/pc/data    head entry presented to decode
//   inst_ready            decode consumes the head entry
//   q_count               allocated entries, filled or not
//   proto_err             sticky: response arrived with nothing outstanding
// ---------------------------------------------------------------------------
module ifetch_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ADDR_W-1:0]        pc_addr,
   input  logic                     pc_valid,
   output logic                     pc_ready,
   input  logic                     flush,
   output logic                     imem_req,
   output logic [ADDR_W-1:0]        imem_addr,
   input  logic                     imem_gnt,
   input  logic                     imem_rvalid,
   input  logic [DATA_W-1:0]        imem_rdata,
   output logic                     inst_valid,
   output logic [ADDR_W-1:0]        inst_pc,
   output logic [DATA_W-1:0]        inst_data,
   input  logic                     inst_ready,
   output logic [$clog2(DEPTH):0]   q_count,
   output logic                     proto_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W:0]   DEPTH_S = (CNT_W+1)'(DEPTH);

   // Entry payload (data path, not reset)
   logic [ADDR_W-1:0] pc_q   [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];

   // Control state
   logic [DEPTH-1:0] filled_q,    filled_d;
   logic [PTR_W-1:0] alloc_ptr_q, alloc_ptr_d;
   logic [PTR_W-1:0] fill_ptr_q,  fill_ptr_d;
   logic [PTR_W-1:0] head_ptr_q,  head_ptr_d;
   logic [CNT_W-1:0] count_q,     count_d;
   logic [CNT_W-1:0] pend_q,      pend_d;    // allocated, not yet filled
   logic [CNT_W-1:0] drop_q,      drop_d;    // responses still to discard
   logic             err_q,       err_d;
   logic [CNT_W:0]   drop_sum;

   logic [ADDR_W-1:0] aligned;
   logic              alloc, fill, pop, stray;

   // Masking (rather than slicing) keeps every pc_addr bit in use.
   assign aligned   = pc_addr & ~ADDR_W'(3);
   assign imem_addr = aligned;

   // rst_n gates the request so it drops immediately on async reset, even
   // while pc_valid is held high.
   assign imem_req  = rst_n & pc_valid & ~flush & (count_q != DEPTH_C);
   assign pc_ready  = imem_req & imem_gnt;
   assign alloc     = pc_ready;

   assign inst_valid = filled_q[head_ptr_q] & (count_q != '0);
   assign inst_pc    = inst_valid ? pc_q[head_ptr_q]   : '0;
   assign inst_data  = inst_valid ? data_q[head_ptr_q] : '0;

   assign pop   = inst_valid & inst_ready & ~flush;
   assign fill  = imem_rvalid & (drop_q == '0) & (pend_q != '0) & ~flush;
   assign stray = imem_rvalid & (drop_q == '0) & (pend_q == '0);

   assign q_count   = count_q;
   assign proto_err = err_q;

   always_comb begin
      filled_d    = filled_q;
      alloc_ptr_d = alloc_ptr_q;
      fill_ptr_d  = fill_ptr_q;
      head_ptr_d  = head_ptr_q;
      count_d     = count_q;
      pend_d      = pend_q;
      drop_d      = drop_q;
      drop_sum    = '0;
      err_d       = err_q | stray;

      if (flush) begin
         filled_d    = '0;
         alloc_ptr_d = '0;
         fill_ptr_d  = '0;
         head_ptr_d  = '0;
         count_d     = '0;
         pend_d      = '0;
         // Everything still owed by memory must be discarded. A response
         // landing in this very cycle is one of those and is consumed now.
         drop_sum = {1'b0, drop_q} + {1'b0, pend_q};
         if (imem_rvalid && (drop_sum != '0))
            drop_sum = drop_sum - (CNT_W+1)'(1);
         drop_d = (drop_sum > DEPTH_S) ? DEPTH_C : drop_sum[CNT_W-1:0];
      end else begin
         if (alloc) begin
            filled_d[alloc_ptr_q] = 1'b0;
            alloc_ptr_d           = alloc_ptr_q + PTR_W'(1);
         end
         if (fill) begin
            filled_d[fill_ptr_q] = 1'b1;
            fill_ptr_d           = fill_ptr_q + PTR_W'(1);
         end
         if (pop)
            head_ptr_d = head_ptr_q + PTR_W'(1);
         if (imem_rvalid && (drop_q != '0))
            drop_d = drop_q - CNT_W'(1);
         count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
         pend_d  = pend_q  + CNT_W'(alloc) - CNT_W'(fill);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filled_q    <= '0;
         alloc_ptr_q <= '0;
         fill_ptr_q  <= '0;
         head_ptr_q  <= '0;
         count_q     <= '0;
         pend_q      <= '0;
         drop_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         filled_q    <= filled_d;
         alloc_ptr_q <= alloc_ptr_d;
         fill_ptr_q  <= fill_ptr_d;
         head_ptr_q  <= head_ptr_d;
         count_q     <= count_d;
         pend_q      <= pend_d;
         drop_q      <= drop_d;
         err_q       <= err_d;
      end
   end

   // Payload writes; visibility is controlled by the filled bits.
   always_ff @(posedge clk) begin
      if (alloc)
         pc_q[alloc_ptr_q] <= aligned;
      if (fill)
         data_q[fill_ptr_q] <= imem_rdata;
   end

endmodule
